// File: rtl/hex_display_arbiter_if.sv
// hex_display_arbiter_if: request/acknowledge and display bus of the
// hex display arbiter. The master side (requesters and scan timer) drives
// requests, data and scan_tick; the slave side (the arbiter) drives the
// acknowledges, the owner indication and the multiplexed display outputs.
interface hex_display_arbiter_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        ack_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        ack_b;
    logic        scan_tick;
    logic [3:0]  hexout;
    logic [3:0]  digit_sel;
    logic [1:0]  owner;

    modport master (
        output req_a, data_a, req_b, data_b, scan_tick,
        input  ack_a, ack_b, hexout, digit_sel, owner
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, scan_tick,
        output ack_a, ack_b, hexout, digit_sel, owner
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: two-requester round-robin arbiter owning a 16-bit
// display register, shown nibble by nibble on a 4-digit multiplexed
// 7-segment display (active-low digit enables).
// A grant acknowledges for one cycle, then the value is held for
// HOLD_CYCLES cycles before the next grant is considered.
// Optional feature macro: HEXDISP_BLANK_EN enables leading-zero blanking
// (digit 0 is always lit).
module hex_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned SCAN_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_display_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [1:0]  SCAN_LAST = 2'(SCAN_DIGITS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_disp;
    logic [15:0] r_hold_cnt;
    logic [1:0]  r_scan;
    logic        r_last_b;
    logic        r_ack_a;
    logic        r_ack_b;
    logic [1:0]  r_owner;
    logic [3:0]  r_hexout;
    logic [3:0]  r_digit_sel;
    logic        w_arb_a;
    logic        w_arb_b;
    logic [3:0]  w_nibble;
    logic [3:0]  w_digit_sel;

    // Round-robin choice: on a tie the requester not granted last wins.
    always_comb begin
        w_arb_a = bus.req_a && (!bus.req_b || r_last_b);
        w_arb_b = bus.req_b && (!bus.req_a || !r_last_b);
    end

    // Next-state logic. The last HOLD edge arbitrates exactly as IDLE does,
    // so a waiting request is granted on the cycle right after the hold ends
    // and acks are spaced HOLD_CYCLES+1 cycles apart.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_a)      w_next_state = GRANT_A;
                else if (w_arb_b) w_next_state = GRANT_B;
                else              w_next_state = IDLE;
            end
            GRANT_A: w_next_state = HOLD;
            GRANT_B: w_next_state = HOLD;
            HOLD: begin
                if (r_hold_cnt == 16'd0) begin
                    if (w_arb_a)      w_next_state = GRANT_A;
                    else if (w_arb_b) w_next_state = GRANT_B;
                    else              w_next_state = IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, display capture, ownership, acknowledge pulses and hold timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_disp     <= 16'h0000;
            r_hold_cnt <= 16'd0;
            r_last_b   <= 1'b1;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_owner    <= 2'b00;
        end else begin
            r_state <= w_next_state;
            r_ack_a <= (w_next_state == GRANT_A);
            r_ack_b <= (w_next_state == GRANT_B);
            if (w_next_state == GRANT_A) begin
                r_disp   <= bus.data_a;
                r_owner  <= 2'b01;
                r_last_b <= 1'b0;
            end else if (w_next_state == GRANT_B) begin
                r_disp   <= bus.data_b;
                r_owner  <= 2'b10;
                r_last_b <= 1'b1;
            end else begin
                r_disp   <= r_disp;
                r_owner  <= r_owner;
                r_last_b <= r_last_b;
            end
            if ((w_next_state == HOLD) && (r_state != HOLD)) begin
                r_hold_cnt <= HOLD_LOAD;
            end else if ((r_state == HOLD) && (r_hold_cnt != 16'd0)) begin
                r_hold_cnt <= r_hold_cnt - 16'd1;
            end else begin
                r_hold_cnt <= r_hold_cnt;
            end
        end
    end

    // Scan position advances on every scan_tick regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= 2'd0;
        end else if (bus.scan_tick) begin
            if (r_scan == SCAN_LAST) r_scan <= 2'd0;
            else                     r_scan <= r_scan + 2'd1;
        end else begin
            r_scan <= r_scan;
        end
    end

`ifdef HEXDISP_BLANK_EN
    logic [1:0] w_msd;

    // Index of the most significant nonzero nibble (0 when all zero).
    always_comb begin
        if (r_disp[15:12] != 4'h0)     w_msd = 2'd3;
        else if (r_disp[11:8] != 4'h0) w_msd = 2'd2;
        else if (r_disp[7:4] != 4'h0)  w_msd = 2'd1;
        else                           w_msd = 2'd0;
    end
`endif

    // Nibble and active-low digit enable for the current scan slot.
    always_comb begin
        w_nibble    = 4'h0;
        w_digit_sel = 4'b1111;
        case (r_scan)
            2'd0: begin w_nibble = r_disp[3:0];   w_digit_sel = 4'b1110; end
            2'd1: begin w_nibble = r_disp[7:4];   w_digit_sel = 4'b1101; end
            2'd2: begin w_nibble = r_disp[11:8];  w_digit_sel = 4'b1011; end
            2'd3: begin w_nibble = r_disp[15:12]; w_digit_sel = 4'b0111; end
            default: begin w_nibble = 4'h0; w_digit_sel = 4'b1111; end
        endcase
`ifdef HEXDISP_BLANK_EN
        if (r_scan > w_msd) begin
            w_digit_sel = 4'b1111;
        end else begin
            w_digit_sel = w_digit_sel;
        end
`endif
    end

    // Display outputs registered one cycle behind the scan counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hexout    <= 4'h0;
            r_digit_sel <= 4'b1110;
        end else begin
            r_hexout    <= w_nibble;
            r_digit_sel <= w_digit_sel;
        end
    end

    assign bus.ack_a     = r_ack_a;
    assign bus.ack_b     = r_ack_b;
    assign bus.owner     = r_owner;
    assign bus.hexout    = r_hexout;
    assign bus.digit_sel = r_digit_sel;

endmodule
